usb3_rx_lcmd_decode: RTL and testbench
======================================

# usb3_rx_lcmd_decode

Receive-side link command decoder sitting directly downstream of the RX descrambler/SKP-removal stage. It watches the descrambled 32-bit symbol stream (`proc_data`/`proc_datak`/`proc_active`) for the LCSTART framing word. It then captures the following word carrying the two link control word (LCW) copies, checks the copies against each other and against their CRC-5, and presents one decoded link command per cycle pulse to the link-layer state machine. Errors are flagged and counted.

## Interface
- `IDLE_TIMEOUT`, default 4: maximum number of consecutive inactive cycles tolerated between LCSTART and the LCW word before the command is aborted.
- `ERRCNT_W`, default 8: width of the saturating error counter.
- `local_clk`  in  1  stream clock (125 MHz domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  decode enable; when low the FSM is held in IDLE and no outputs pulse.
- `in_active`  in  1  input word valid (descrambler `proc_active`).
- `in_data`  in  32  descrambled symbols; first-in-time symbol in [31:24].
- `in_datak`  in  4  K-flags; [3] pairs with [31:24].
- `lcmd_valid`  out  1  one-cycle pulse: a good link command is on `lcmd_info`.
- `lcmd_info`  out  11  LCW command info bits [10:0]; held until the next `lcmd_valid`.
- `lcmd_err`  out  1  one-cycle pulse: framed command rejected.
- `lcmd_err_code`  out  2  reason: 0 = CRC fail, 1 = copy mismatch, 2 = K-symbol in LCW, 3 = timeout; held until the next error.
- `err_count`  out  `ERRCNT_W`  saturating count of `lcmd_err` pulses.

## Operation
- Constants:
  - SLC = K, 0xDC.
  - EPF = K, 0xF7.
  - LCSTART word = {SLC,SLC,SLC,EPF}, datak 4'b1111, full word only. Word alignment of framing is guaranteed upstream.
- LCW word: `lcw_a` = {data[23:16], data[31:24]}, `lcw_b` = {data[7:0], data[15:8]}, i.e. the first symbol of each copy carries bits [7:0].
- LCW format: [15:11] CRC-5, [10:0] command info.
- CRC-5 over info[10:0], processed LSB first:
  - polynomial x^5+x^2+1;
  - seed 5'b11111;
  - result inverted.
- FSM states:
  - IDLE → WAIT_LCW on an active LCSTART word.
  - WAIT_LCW: gap counter cleared on entry.
    - Active word that is itself LCSTART: restart; stay in WAIT_LCW, counter cleared, no error.
    - Any other active word: evaluate it as the LCW word and return to IDLE.
    - Inactive cycle: increment the gap counter. When the counter reaches `IDLE_TIMEOUT`, pulse an error with code 3 and return to IDLE.
- LCW evaluation priority (first hit wins):
  1. Any `in_datak` bit set → code 2.
  2. `lcw_a` != `lcw_b` → code 1.
  3. CRC of `lcw_a` wrong → code 0.
  4. Otherwise `lcmd_valid`, with `lcmd_info` = `lcw_a`[10:0].
- Active non-LCSTART words seen in IDLE are ignored (packets and ordered sets pass through unseen).
- `err_count` increments on every `lcmd_err` and saturates at all-ones; it is cleared only by reset.
- `enable` low: FSM forced to IDLE next cycle with no error, and the gap counter cleared.

## Timing
- All outputs are registered.
- Reset values: `lcmd_valid` 0, `lcmd_info` 0, `lcmd_err` 0, `lcmd_err_code` 0, `err_count` 0, FSM IDLE.
- Latency: an LCW word sampled at edge N gives `lcmd_valid`/`lcmd_err` high for the cycle after edge N+1 (one register stage).
- Minimum spacing: back-to-back commands (LCSTART, LCW, LCSTART, LCW on consecutive cycles) are decoded at full rate with no bubbles.
- Gap tolerance: an inactive gap of `IDLE_TIMEOUT`-1 cycles between LCSTART and LCW is accepted. This absorbs the single-cycle `proc_active` drop the descrambler produces when a SKP follows a word.
- `lcmd_valid` and `lcmd_err` are never asserted in the same cycle.
- Reset asserted mid-command: everything returns to reset values immediately (asynchronous) and no pulse is emitted.

## Structure
- Shared package/include: SLC/EPF symbol constants, LCW field positions, `lcmd_err_code` encodings, CRC-5 polynomial and seed.
- One natural sub-module, `usb3_crc5_lcw`: combinational CRC-5 over 11 bits, reused by the TX link command generator.

## Test plan
- LCSTART then LCW with info 11'h000 and correct CRC in both copies on the next cycle → `lcmd_valid` pulse 2 cycles after the LCW word; `lcmd_info` = 11'h000; `err_count` 0.
- Same command with one inactive cycle between LCSTART and LCW (info 11'h2A5) → `lcmd_valid`, `lcmd_info` = 11'h2A5; with 4 inactive cycles → `lcmd_err`, code 3, no valid.
- LCW copies differing in bit 0 → `lcmd_err` code 1; then a correct-info LCW with CRC field bit 11 flipped in both copies → code 0; `err_count` = 2.
- LCW word with `in_datak` = 4'b0100 → code 2; `lcmd_info` unchanged from the previous good command.
- 300 consecutive error-producing commands → `err_count` saturates at 8'hFF; `reset_n` pulsed low mid-LCSTART → all outputs 0, next good command decodes normally.
- LCSTART, LCSTART, LCW → single `lcmd_valid`, no error; `enable` low between LCSTART and LCW → no pulse at all.

Source files
------------

// File: rtl/usb3_rx_lcmd_decode_pkg.sv
// Shared link command constants: framing symbols, LCW field layout, error codes
// and the CRC-5 definition used by both the RX decoder and the TX generator.
package usb3_rx_lcmd_decode_pkg;

    localparam logic [7:0]  SYM_SLC       = 8'hDC;
    localparam logic [7:0]  SYM_EPF       = 8'hF7;
    localparam logic [31:0] LCSTART_DATA  = {SYM_SLC, SYM_SLC, SYM_SLC, SYM_EPF};
    localparam logic [3:0]  LCSTART_DATAK = 4'b1111;

    localparam int LCW_CRC_MSB  = 15;
    localparam int LCW_CRC_LSB  = 11;
    localparam int LCW_INFO_MSB = 10;

    localparam logic [4:0] CRC5_POLY = 5'b00101;
    localparam logic [4:0] CRC5_SEED = 5'b11111;

    typedef enum logic [1:0] {
        ERR_CRC      = 2'd0,
        ERR_MISMATCH = 2'd1,
        ERR_KSYM     = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } lcmd_err_e;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_LCW = 1'b1
    } lcmd_state_e;

    function automatic logic is_lcstart(input logic [31:0] data, input logic [3:0] datak);
        return (data == LCSTART_DATA) && (datak == LCSTART_DATAK);
    endfunction

    // Serial CRC-5, info bit 0 enters first; final remainder is inverted.
    function automatic logic [4:0] crc5_calc(input logic [10:0] info);
        logic [4:0] crc;
        logic       fb;
        crc = CRC5_SEED;
        for (int i = 0; i < 11; i++) begin
            fb  = info[i] ^ crc[4];
            crc = {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
        end
        return ~crc;
    endfunction

endpackage

// File: rtl/usb3_crc5_lcw.sv
// Combinational CRC-5 over the 11 link control word info bits.
module usb3_crc5_lcw
    import usb3_rx_lcmd_decode_pkg::*;
(
    input  logic [10:0] info,
    output logic [4:0]  crc
);

    assign crc = crc5_calc(info);

endmodule

// File: rtl/usb3_rx_lcmd_decode.sv
// Receive link command decoder: finds LCSTART, captures the LCW word, validates
// both copies and the CRC-5, and emits one registered valid or error pulse.
module usb3_rx_lcmd_decode
    import usb3_rx_lcmd_decode_pkg::*;
#(
    parameter int IDLE_TIMEOUT = 4,
    parameter int ERRCNT_W     = 8
) (
    input  logic                local_clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                in_active,
    input  logic [31:0]         in_data,
    input  logic [3:0]          in_datak,
    output logic                lcmd_valid,
    output logic [10:0]         lcmd_info,
    output logic                lcmd_err,
    output logic [1:0]          lcmd_err_code,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int                 GAP_W    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(IDLE_TIMEOUT - 1);
    localparam logic [ERRCNT_W-1:0] CNT_MAX = {ERRCNT_W{1'b1}};

    lcmd_state_e      state_r;
    logic [GAP_W-1:0] gap_cnt_r;
    logic             st1_eval_r;
    logic             st1_timeout_r;
    logic             st1_ksym_r;
    logic [31:0]      st1_data_r;

    logic             lcstart_s;
    logic [15:0]      lcw_a_s;
    logic [15:0]      lcw_b_s;
    logic [4:0]       crc_s;
    logic             good_s;
    logic             bad_s;
    lcmd_err_e        code_s;

    assign lcstart_s = is_lcstart(in_data, in_datak);

    // The first symbol of each copy carries the low byte of the LCW.
    assign lcw_a_s = {st1_data_r[23:16], st1_data_r[31:24]};
    assign lcw_b_s = {st1_data_r[7:0],   st1_data_r[15:8]};

    usb3_crc5_lcw u_crc5 (
        .info (lcw_a_s[LCW_INFO_MSB:0]),
        .crc  (crc_s)
    );

    // Framing FSM; captures the LCW word (or a timeout) into the evaluation stage.
    always_ff @(posedge local_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            gap_cnt_r     <= {GAP_W{1'b0}};
            st1_eval_r    <= 1'b0;
            st1_timeout_r <= 1'b0;
            st1_ksym_r    <= 1'b0;
            st1_data_r    <= 32'h0000_0000;
        end else if (!enable) begin
            state_r       <= ST_IDLE;
            gap_cnt_r     <= {GAP_W{1'b0}};
            st1_eval_r    <= 1'b0;
            st1_timeout_r <= 1'b0;
        end else begin
            st1_eval_r    <= 1'b0;
            st1_timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    gap_cnt_r <= {GAP_W{1'b0}};
                    if (in_active && lcstart_s) begin
                        state_r <= ST_WAIT_LCW;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_LCW: begin
                    if (in_active) begin
                        gap_cnt_r <= {GAP_W{1'b0}};
                        if (lcstart_s) begin
                            state_r <= ST_WAIT_LCW;
                        end else begin
                            state_r    <= ST_IDLE;
                            st1_eval_r <= 1'b1;
                            st1_ksym_r <= |in_datak;
                            st1_data_r <= in_data;
                        end
                    end else if (gap_cnt_r == GAP_LAST) begin
                        state_r       <= ST_IDLE;
                        gap_cnt_r     <= {GAP_W{1'b0}};
                        st1_timeout_r <= 1'b1;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    gap_cnt_r <= {GAP_W{1'b0}};
                end
            endcase
        end
    end

    // Evaluate the captured word; the first failing check decides the code.
    always_comb begin
        good_s = 1'b0;
        bad_s  = 1'b0;
        code_s = ERR_CRC;
        if (st1_timeout_r) begin
            bad_s  = 1'b1;
            code_s = ERR_TIMEOUT;
        end else if (st1_eval_r) begin
            if (st1_ksym_r) begin
                bad_s  = 1'b1;
                code_s = ERR_KSYM;
            end else if (lcw_a_s != lcw_b_s) begin
                bad_s  = 1'b1;
                code_s = ERR_MISMATCH;
            end else if (lcw_a_s[LCW_CRC_MSB:LCW_CRC_LSB] != crc_s) begin
                bad_s  = 1'b1;
                code_s = ERR_CRC;
            end else begin
                good_s = 1'b1;
            end
        end else begin
            good_s = 1'b0;
            bad_s  = 1'b0;
        end
    end

    // Registered result pulses, held info/code and the saturating error counter.
    always_ff @(posedge local_clk or negedge reset_n) begin
        if (!reset_n) begin
            lcmd_valid    <= 1'b0;
            lcmd_info     <= 11'h000;
            lcmd_err      <= 1'b0;
            lcmd_err_code <= 2'd0;
            err_count     <= {ERRCNT_W{1'b0}};
        end else begin
            lcmd_valid <= good_s & enable;
            lcmd_err   <= bad_s & enable;
            if (good_s && enable) begin
                lcmd_info <= lcw_a_s[LCW_INFO_MSB:0];
            end else begin
                lcmd_info <= lcmd_info;
            end
            if (bad_s && enable) begin
                lcmd_err_code <= code_s;
                if (err_count != CNT_MAX) begin
                    err_count <= err_count + ERRCNT_W'(1);
                end else begin
                    err_count <= err_count;
                end
            end else begin
                lcmd_err_code <= lcmd_err_code;
                err_count     <= err_count;
            end
        end
    end

endmodule

// File: tb/tb_usb3_rx_lcmd_decode.sv
// Directed bench for the receive link command decoder with hand-computed LCWs.
module tb_usb3_rx_lcmd_decode;

    // LCW = {CRC-5, info}; CRC values worked out by hand for these infos.
    localparam logic [15:0] LCW_000 = 16'h4000; // info 000, crc 5'h08
    localparam logic [15:0] LCW_2A5 = 16'hEAA5; // info 2A5, crc 5'h1D
    localparam logic [15:0] LCW_7FF = 16'h17FF; // info 7FF, crc 5'h02
    localparam logic [31:0] LCSTART = 32'hDCDC_DCF7;

    logic        local_clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        in_active;
    logic [31:0] in_data;
    logic [3:0]  in_datak;
    logic        lcmd_valid;
    logic [10:0] lcmd_info;
    logic        lcmd_err;
    logic [1:0]  lcmd_err_code;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_err = 0;
    int n_both = 0;
    int v0, e0;
    logic [7:0] exp_cnt = 8'h00;

    always #5 local_clk = ~local_clk;

    usb3_rx_lcmd_decode #(.IDLE_TIMEOUT(4), .ERRCNT_W(8)) dut (
        .local_clk     (local_clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .in_active     (in_active),
        .in_data       (in_data),
        .in_datak      (in_datak),
        .lcmd_valid    (lcmd_valid),
        .lcmd_info     (lcmd_info),
        .lcmd_err      (lcmd_err),
        .lcmd_err_code (lcmd_err_code),
        .err_count     (err_count)
    );

    always @(negedge local_clk) begin
        if (lcmd_valid === 1'b1) n_valid++;
        if (lcmd_err === 1'b1) n_err++;
        if (lcmd_valid === 1'b1 && lcmd_err === 1'b1) n_both++;
    end

    function automatic logic [31:0] pack(input logic [15:0] a, input logic [15:0] b);
        return {a[7:0], a[15:8], b[7:0], b[15:8]};
    endfunction

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic act);
        @(negedge local_clk);
        in_data   = d;
        in_datak  = k;
        in_active = act;
    endtask

    task automatic idle(input int n);
        repeat (n) send(32'h0, 4'h0, 1'b0);
    endtask

    task automatic send_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] k, input int gap);
        send(LCSTART, 4'hF, 1'b1);
        idle(gap);
        send(pack(a, b), k, 1'b1);
        idle(4);
    endtask

    task automatic bump_exp();
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; in_active = 1'b0; in_data = 32'h0; in_datak = 4'h0;
        #12;
        checks++; if (lcmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", lcmd_valid); end
        checks++; if (lcmd_info !== 11'h000) begin errors++; $display("FAIL reset_info got=%h exp=000", lcmd_info); end
        checks++; if (lcmd_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", lcmd_err); end
        checks++; if (lcmd_err_code !== 2'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", lcmd_err_code); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_cnt got=%h exp=00", err_count); end
        @(negedge local_clk);
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        send(LCSTART, 4'hF, 1'b1);
        send(pack(LCW_000, LCW_000), 4'h0, 1'b1);
        send(32'h0, 4'h0, 1'b0);
        checks++; if (lcmd_valid !== 1'b0) begin errors++; $display("FAIL basic_early got=%b exp=0", lcmd_valid); end
        @(negedge local_clk);
        checks++; if (lcmd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", lcmd_valid); end
        checks++; if (lcmd_info !== 11'h000) begin errors++; $display("FAIL basic_info got=%h exp=000", lcmd_info); end
        checks++; if (lcmd_err !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", lcmd_err); end
        @(negedge local_clk);
        checks++; if (lcmd_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got=%b exp=0", lcmd_valid); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL basic_cnt got=%h exp=00", err_count); end
        idle(2);
    endtask

    task automatic test_gap();
        v0 = n_valid; e0 = n_err;
        send_cmd(LCW_2A5, LCW_2A5, 4'h0, 1);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL gap1_valid got=%0d exp=1", n_valid - v0); end
        checks++; if (lcmd_info !== 11'h2A5) begin errors++; $display("FAIL gap1_info got=%h exp=2a5", lcmd_info); end
        v0 = n_valid;
        send_cmd(LCW_7FF, LCW_7FF, 4'h0, 3);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL gap3_valid got=%0d exp=1", n_valid - v0); end
        checks++; if (lcmd_info !== 11'h7FF) begin errors++; $display("FAIL gap3_info got=%h exp=7ff", lcmd_info); end
        checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL gap_noerr got=%0d exp=0", n_err - e0); end
        v0 = n_valid;
        send_cmd(LCW_2A5, LCW_2A5, 4'h0, 4);
        bump_exp();
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL gap4_valid got=%0d exp=0", n_valid - v0); end
        checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL gap4_err got=%0d exp=1", n_err - e0); end
        checks++; if (lcmd_err_code !== 2'd3) begin errors++; $display("FAIL gap4_code got=%0d exp=3", lcmd_err_code); end
        checks++; if (lcmd_info !== 11'h7FF) begin errors++; $display("FAIL gap4_info got=%h exp=7ff", lcmd_info); end
    endtask

    task automatic test_errors();
        v0 = n_valid; e0 = n_err;
        send_cmd(LCW_2A5, LCW_2A5 ^ 16'h0001, 4'h0, 0);
        bump_exp();
        checks++; if (lcmd_err_code !== 2'd1) begin errors++; $display("FAIL mismatch_code got=%0d exp=1", lcmd_err_code); end
        send_cmd(LCW_2A5 ^ 16'h0800, LCW_2A5 ^ 16'h0800, 4'h0, 0);
        bump_exp();
        checks++; if (lcmd_err_code !== 2'd0) begin errors++; $display("FAIL crc_code got=%0d exp=0", lcmd_err_code); end
        checks++; if (n_err - e0 !== 2) begin errors++; $display("FAIL err_pulses got=%0d exp=2", n_err - e0); end
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL err_novalid got=%0d exp=0", n_valid - v0); end
        checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL err_cnt got=%h exp=%h", err_count, exp_cnt); end
    endtask

    task automatic test_ksym();
        send_cmd(LCW_2A5, LCW_2A5, 4'h0, 0);
        v0 = n_valid; e0 = n_err;
        send_cmd(LCW_000, LCW_000, 4'b0100, 0);
        bump_exp();
        checks++; if (lcmd_err_code !== 2'd2) begin errors++; $display("FAIL ksym_code got=%0d exp=2", lcmd_err_code); end
        checks++; if (lcmd_info !== 11'h2A5) begin errors++; $display("FAIL ksym_info got=%h exp=2a5", lcmd_info); end
        checks++; if (n_valid - v0 !== 0 || n_err - e0 !== 1) begin errors++; $display("FAIL ksym_pulses got=%0d/%0d exp=0/1", n_valid - v0, n_err - e0); end
    endtask

    task automatic test_back_to_back();
        v0 = n_valid; e0 = n_err;
        send(LCSTART, 4'hF, 1'b1);
        send(pack(LCW_000, LCW_000), 4'h0, 1'b1);
        send(LCSTART, 4'hF, 1'b1);
        send(pack(LCW_7FF, LCW_7FF), 4'h0, 1'b1);
        checks++; if (lcmd_valid !== 1'b1 || lcmd_info !== 11'h000) begin errors++; $display("FAIL b2b_first got=%b/%h exp=1/000", lcmd_valid, lcmd_info); end
        idle(2);
        checks++; if (lcmd_valid !== 1'b1 || lcmd_info !== 11'h7FF) begin errors++; $display("FAIL b2b_second got=%b/%h exp=1/7ff", lcmd_valid, lcmd_info); end
        idle(3);
        checks++; if (n_valid - v0 !== 2 || n_err - e0 !== 0) begin errors++; $display("FAIL b2b_pulses got=%0d/%0d exp=2/0", n_valid - v0, n_err - e0); end
    endtask

    task automatic test_restart_enable();
        v0 = n_valid; e0 = n_err;
        send(LCSTART, 4'hF, 1'b1);
        send_cmd(LCW_2A5, LCW_2A5, 4'h0, 0);
        checks++; if (n_valid - v0 !== 1 || n_err - e0 !== 0) begin errors++; $display("FAIL restart_pulses got=%0d/%0d exp=1/0", n_valid - v0, n_err - e0); end
        send_cmd(LCW_000, LCW_000, 4'h0, 0);
        v0 = n_valid; e0 = n_err;
        send(LCSTART, 4'hF, 1'b1);
        send(32'h0, 4'h0, 1'b0);
        enable = 1'b0;
        send(32'h0, 4'h0, 1'b0);
        enable = 1'b1;
        send(pack(LCW_7FF, LCW_7FF), 4'h0, 1'b1);
        idle(6);
        checks++; if (n_valid - v0 !== 0 || n_err - e0 !== 0) begin errors++; $display("FAIL enable_pulses got=%0d/%0d exp=0/0", n_valid - v0, n_err - e0); end
        checks++; if (lcmd_info !== 11'h000) begin errors++; $display("FAIL enable_info got=%h exp=000", lcmd_info); end
    endtask

    task automatic test_saturate();
        e0 = n_err;
        for (int i = 0; i < 300; i++) begin
            send(LCSTART, 4'hF, 1'b1);
            send(pack(LCW_2A5, LCW_000), 4'h0, 1'b1);
            bump_exp();
        end
        idle(4);
        checks++; if (n_err - e0 !== 300) begin errors++; $display("FAIL sat_pulses got=%0d exp=300", n_err - e0); end
        checks++; if (err_count !== 8'hFF || exp_cnt !== 8'hFF) begin errors++; $display("FAIL sat_cnt got=%h exp=ff", err_count); end
        checks++; if (lcmd_err_code !== 2'd1) begin errors++; $display("FAIL sat_code got=%0d exp=1", lcmd_err_code); end
    endtask

    task automatic test_reset_mid();
        v0 = n_valid; e0 = n_err;
        send(LCSTART, 4'hF, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (lcmd_valid !== 1'b0 || lcmd_err !== 1'b0) begin errors++; $display("FAIL rstmid_pulse got=%b/%b exp=0/0", lcmd_valid, lcmd_err); end
        checks++; if (lcmd_info !== 11'h000 || lcmd_err_code !== 2'd0) begin errors++; $display("FAIL rstmid_hold got=%h/%0d exp=000/0", lcmd_info, lcmd_err_code); end
        checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL rstmid_cnt got=%h exp=00", err_count); end
        send(pack(LCW_7FF, LCW_7FF), 4'h0, 1'b1);
        reset_n = 1'b1;
        exp_cnt = 8'h00;
        idle(4);
        checks++; if (n_valid - v0 !== 0 || n_err - e0 !== 0) begin errors++; $display("FAIL rstmid_quiet got=%0d/%0d exp=0/0", n_valid - v0, n_err - e0); end
        send_cmd(LCW_2A5, LCW_2A5, 4'h0, 0);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL rstmid_next got=%0d exp=1", n_valid - v0); end
        checks++; if (lcmd_info !== 11'h2A5) begin errors++; $display("FAIL rstmid_info got=%h exp=2a5", lcmd_info); end
        checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL rstmid_cnt2 got=%h exp=%h", err_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_errors();
        test_ksym();
        test_back_to_back();
        test_restart_enable();
        test_saturate();
        test_reset_mid();
        checks++; if (n_both !== 0) begin errors++; $display("FAIL valid_err_overlap got=%0d exp=0", n_both); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
